ccr_unit: RTL



---
 rtl/ccr_unit.sv | 109 ++++++++++
 1 files changed

// File: rtl/ccr_unit.sv
// Condition-code register for the 16-bit core: masked flag commit,
// jump resolution with flag consume, and interrupt shadow save/restore.
module ccr_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       flags_we,
  input  logic [2:0] alu_flags,
  input  logic [2:0] flag_mask,
  input  logic       setc,
  input  logic       clrc,
  input  logic       jmp_valid,
  input  logic [1:0] jmp_cond,
  input  logic       int_ack,
  input  logic       rti,
  output logic [2:0] ccr,
  output logic       branch_taken,
  output logic       int_saved,
  output logic       save_overrun
);

  typedef enum logic {IDLE, SAVED} state_t;

  state_t     state, stateNext;
  logic [2:0] shadow, shadowNext;
  logic [2:0] ccrCalc, ccrNext;
  logic       condHit;
  logic       overrunNext;

  always_comb begin
    condHit = 1'b0;
    unique case (jmp_cond)
      2'b00: condHit = ccr[0];
      2'b01: condHit = ccr[1];
      2'b10: condHit = ccr[2];
      2'b11: condHit = 1'b1;
    endcase
  end

  assign branch_taken = jmp_valid & condHit;

  // consume, then ALU merge, then setc/clrc; later steps win per bit
  always_comb begin
    ccrCalc = ccr;
    if (branch_taken) begin
      unique case (jmp_cond)
        2'b00: ccrCalc[0] = 1'b0;
        2'b01: ccrCalc[1] = 1'b0;
        2'b10: ccrCalc[2] = 1'b0;
        2'b11: ccrCalc = ccr;
      endcase
    end
    if (flags_we)
      ccrCalc = (ccrCalc & ~flag_mask) | (alu_flags & flag_mask);
    if (setc)
      ccrCalc[2] = 1'b1;
    if (clrc)
      ccrCalc[2] = 1'b0;
  end

  always_comb begin
    stateNext   = state;
    shadowNext  = shadow;
    ccrNext     = ccrCalc;
    overrunNext = 1'b0;
    unique case (state)
      IDLE: begin
        if (int_ack) begin
          stateNext  = SAVED;
          shadowNext = ccrCalc;
        end
        if (rti)
          overrunNext = 1'b1;
      end
      SAVED: begin
        if (rti) begin
          ccrNext = shadow;
          if (!int_ack)
            stateNext = IDLE;
        end else if (int_ack) begin
          overrunNext = 1'b1;
        end
      end
    endcase
    if (stall) begin
      stateNext   = state;
      shadowNext  = shadow;
      ccrNext     = ccr;
      overrunNext = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      shadow       <= 3'b000;
      ccr          <= 3'b000;
      save_overrun <= 1'b0;
    end else begin
      state        <= stateNext;
      shadow       <= shadowNext;
      ccr          <= ccrNext;
      save_overrun <= overrunNext;
    end
  end

  assign int_saved = (state == SAVED);

endmodule
